// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command/response sequencer driving the combinational 4-bit ALU
module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_opcode,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_carry_in,
    input  logic       cmd_use_acc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    output logic       alu_carry_in,
    input  logic [3:0] alu_result,
    input  logic       alu_carry_out,
    input  logic [3:0] alu_remainder,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic [3:0] rsp_remainder,
    output logic       rsp_zero,
    output logic [3:0] acc,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only the add-with-carry opcode produces a meaningful carry-out.
    localparam logic [2:0] OP_ADD = 3'b111;

    state_t state;

    // Handshake and status decodes straight from the registered state.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_zero  = (rsp_result == 4'd0);

    // Sequencer: load ALU inputs on accept, capture after one settle cycle, hold response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rsp_valid     <= 1'b0;
            rsp_result    <= 4'd0;
            rsp_carry     <= 1'b0;
            rsp_remainder <= 4'd0;
            acc           <= 4'd0;
            op_count      <= 8'd0;
            alu_a         <= 4'd0;
            alu_b         <= 4'd0;
            alu_opcode    <= 3'd0;
            alu_carry_in  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a        <= cmd_use_acc ? acc : cmd_a;
                        alu_b        <= cmd_b;
                        alu_opcode   <= cmd_opcode;
                        alu_carry_in <= cmd_carry_in;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result    <= alu_result;
                    rsp_remainder <= alu_remainder;
                    rsp_carry     <= (alu_opcode == OP_ADD) ? alu_carry_out : 1'b0;
                    acc           <= alu_result;
                    op_count      <= op_count + 8'd1;
                    rsp_valid     <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential front end for the combinational 4-bit ALU: accepts one operation command per valid/ready handshake, registers the operands and opcode onto the ALU inputs, holds them stable for one settle cycle, and captures result, carry, remainder and status flags into a response register. It keeps a 4-bit accumulator so chained operations can use the previous result as operand A. It sits directly upstream of the ALU and is the only driver of the ALU's inputs.

## Interface
- No parameters. Widths are fixed to the ALU: 4-bit data, 3-bit opcode.
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_opcode  input  3  ALU opcode
- cmd_a  input  4  operand A
- cmd_b  input  4  operand B
- cmd_carry_in  input  1  carry/borrow-in for the ALU
- cmd_use_acc  input  1  1: use the accumulator as operand A instead of cmd_a
- alu_a  output  4  registered operand A to ALU
- alu_b  output  4  registered operand B to ALU
- alu_opcode  output  3  registered opcode to ALU
- alu_carry_in  output  1  registered carry-in to ALU
- alu_result  input  4  ALU result
- alu_carry_out  input  1  ALU carry-out
- alu_remainder  input  4  ALU remainder
- rsp_valid  output  1  response held valid
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  4  captured result
- rsp_carry  output  1  captured carry
- rsp_remainder  output  4  captured remainder
- rsp_zero  output  1  1 when rsp_result == 0
- acc  output  4  accumulator value
- busy  output  1  1 when the state is not IDLE
- op_count  output  8  number of completed responses, wraps modulo 256

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, the block loads the alu_* registers and moves to EXEC.
  - alu_a is loaded with acc when cmd_use_acc=1, otherwise with cmd_a.
- EXEC: lasts exactly 1 cycle; the ALU inputs are stable and the ALU output settles. At the end of EXEC the block:
  - captures rsp_result=alu_result and rsp_remainder=alu_remainder;
  - captures rsp_carry = alu_carry_out when alu_opcode==3'b111, otherwise 0;
  - sets rsp_zero from the captured result;
  - loads acc with alu_result;
  - increments op_count;
  - moves to RESP.
- RESP: rsp_valid=1 and all rsp_* outputs are held constant.
  - On rsp_ready=1 the block moves to IDLE; rsp_valid drops the next cycle.
  - While rsp_ready=0 the block stays in RESP indefinitely.
- cmd_ready is 0 in EXEC and RESP. Commands presented during those states are not consumed.
- alu_* registers hold their last values outside IDLE→EXEC loads.
- Reset values, all applied synchronously when rst=1 on any edge regardless of state:
  - state=IDLE, cmd_ready=1 (after reset), rsp_valid=0, busy=0;
  - rsp_result=0, rsp_carry=0, rsp_remainder=0, rsp_zero=1;
  - acc=0, op_count=0;
  - alu_a=0, alu_b=0, alu_opcode=0, alu_carry_in=0.
- Reset during EXEC or RESP discards the in-flight operation. acc and op_count are not updated.
- op_count wraps from 255 to 0.

## Timing
- Cycle 0: cmd handshake edge.
- Cycle 1: EXEC.
- Rising edge ending cycle 1: capture; rsp_valid=1 from cycle 2. Accept-to-valid latency is 2 cycles.
- With rsp_ready held at 1, rsp_valid is high for exactly 1 cycle. The next cmd_ready comes the cycle after the response handshake.
- Maximum throughput is 1 op per 3 cycles.
- cmd_use_acc on a command accepted the cycle after a response handshake sees the updated acc.
- All outputs are registered, except rsp_zero, busy and cmd_ready. Those three may be combinational decodes of registered state.

## Test plan
- Add with carry: opcode 3'b111, a=9, b=8, cin=0.
  - rsp_result=1, rsp_carry=1, rsp_zero=0, acc=1, rsp_valid 2 cycles after accept.
- AND to zero: opcode 3'b000, a=4'hC, b=4'h3.
  - rsp_result=0, rsp_zero=1, rsp_carry=0 even if the ALU's carry_out is stale at 1.
- Accumulate chain: ADD 3+4 (cin 0) gives rsp_result=7. Then ADD with use_acc=1, cmd_a=4'hF, b=2 gives rsp_result=9 and acc=9; cmd_a is ignored.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 and a different command.
  - rsp_* outputs stay constant, cmd_ready=0, busy=1, the second command is not consumed.
  - After rsp_ready=1, the second command is accepted in the first IDLE cycle.
- Reset mid-operation: assert rst during EXEC, after acc=5 and op_count=3.
  - Next cycle: rsp_valid=0, acc=0, op_count=0, cmd_ready=1, no response emitted.
- Counter wrap: 256 back-to-back ops (rsp_ready=1).
  - op_count reads 255 after the 255th op and 0 after the 256th; spacing is 3 cycles per op.
